// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end. It owns the fetch PC and issues one instruction
// memory request at a time. Fetched {pc, instruction} pairs go into a small
// in-order queue that feeds decode, so a decode stall never drops or re-fetches
// a word. Branch/jump redirects from execute flush the queue and steer the PC.
// A response that belongs to a request issued before a redirect is discarded.
//
// Parameters
//   XLEN      data/address width
//   RESET_PC  fetch address after reset
//   QDEPTH    queue entries (power of two, >= 2)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   imem_req      fetch request valid
//   imem_addr     fetch address, word aligned
//   imem_ack      response valid, qualifies imem_rdata
//   imem_rdata    fetched instruction
//   redirect      execute-stage branch/jump taken
//   redirect_pc   redirect target (low two bits ignored)
//   stall_d       decode cannot accept this cycle
//   inst_valid_d  inst_d/pc_d are valid
//   inst_d        instruction presented to decode
//   pc_d          PC of inst_d
//
// Handshakes
//   Memory side: a request is in flight from the first cycle imem_req is high
//   until the cycle in which imem_ack is high, and imem_addr does not change
//   in between. imem_ack may come in the same cycle as the request or in any
//   later cycle. imem_ack is ignored while imem_req is low. Only one request
//   is ever in flight.
//   Decode side: a word is consumed in a cycle where inst_valid_d is high and
//   stall_d is low.
//
// Build option
//   FETCH_BYPASS_EN  when defined, a response that arrives while the queue is
//                    empty, with no redirect and no decode stall, goes straight
//                    to inst_d/pc_d in the same cycle and is not queued.
// -----------------------------------------------------------------------------
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              QDEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            stall_d,
   output logic            inst_valid_d,
   output logic [31:0]     inst_d,
   output logic [XLEN-1:0] pc_d
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   // IDLE    : no request in flight; request whenever the queue has room
   // WAIT    : request in flight, its response will be kept
   // DISCARD : request in flight, but a redirect made its response stale
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] addr_next;

   // Queue storage and bookkeeping
   logic [XLEN-1:0] q_pc   [QDEPTH];
   logic [31:0]     q_inst [QDEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [CW-1:0]   count;

   logic            room;
   logic            q_valid;
   logic            resp;
   logic            take;
   logic            bypass;
   logic            push;
   logic            pop;
   logic [XLEN-1:0] redirect_aligned;

   // The low bits of the redirect target are dropped when it is aligned.
   logic            unused_rpc_bits;
   assign unused_rpc_bits = ^redirect_pc[1:0];

   assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
   assign room             = (count < CW'(QDEPTH));
   assign q_valid          = (count != '0);

   // --------------------------------------------------------------------------
   // Request side. In IDLE the request address is the live PC; once a request
   // is in flight the address is frozen in addr_q. A redirect can then move
   // the PC without disturbing the address the memory is still serving.
   // --------------------------------------------------------------------------
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = pc;
      case (state)
         S_IDLE: begin
            imem_req  = room;
            imem_addr = pc;
         end
         S_WAIT, S_DISCARD: begin
            imem_req  = 1'b1;
            imem_addr = addr_q;
         end
         default: begin
            imem_req  = 1'b0;
            imem_addr = pc;
         end
      endcase
      // Nothing is requested while reset is held.
      if (rst) begin
         imem_req = 1'b0;
      end
   end

   // A response counts only if it answers a request made in this cycle, and
   // it is kept only if the request was not made stale by a redirect.
   assign resp = imem_req && imem_ack;
   assign take = resp && (state != S_DISCARD) && !redirect;

`ifdef FETCH_BYPASS_EN
   // An empty queue with a ready decode stage lets the word skip the queue.
   assign bypass = take && !q_valid && !stall_d;
`else
   assign bypass = 1'b0;
`endif

   assign push = take && !bypass;
   // A redirect flushes the queue, so no pop is counted in its cycle.
   assign pop  = q_valid && !stall_d && !redirect;

   // --------------------------------------------------------------------------
   // Decode-side outputs, forced to zero during reset and when nothing is valid
   // --------------------------------------------------------------------------
   always_comb begin
      inst_valid_d = 1'b0;
      inst_d       = '0;
      pc_d         = '0;
      if (!rst) begin
         if (bypass) begin
            inst_valid_d = 1'b1;
            inst_d       = imem_rdata;
            pc_d         = imem_addr;
         end else if (q_valid) begin
            inst_valid_d = 1'b1;
            inst_d       = q_inst[head];
            pc_d         = q_pc[head];
         end
      end
   end

   // --------------------------------------------------------------------------
   // FSM next state, next PC and frozen request address
   // --------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      addr_next  = addr_q;
      pc_next    = pc;

      case (state)
         S_IDLE: begin
            if (imem_req && !imem_ack) begin
               // Request goes out and stays in flight. If a redirect arrives
               // alongside it, its eventual response is already stale.
               addr_next  = pc;
               state_next = redirect ? S_DISCARD : S_WAIT;
            end
            // A same-cycle ack (combinational memory) completes the request
            // immediately, so the FSM stays in IDLE.
         end
         S_WAIT: begin
            if (imem_ack) begin
               state_next = S_IDLE;
            end else if (redirect) begin
               state_next = S_DISCARD;
            end
         end
         S_DISCARD: begin
            if (imem_ack) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // The redirect target overrides the sequential increment.
      if (redirect) begin
         pc_next = redirect_aligned;
      end else if (take) begin
         pc_next = pc + XLEN'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         pc     <= RESET_PC;
         addr_q <= RESET_PC;
      end else begin
         state  <= state_next;
         pc     <= pc_next;
         addr_q <= addr_next;
      end
   end

   // --------------------------------------------------------------------------
   // Queue pointers and occupancy. Requests only issue while there is room, so
   // a push always has a free slot.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (redirect) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PW'(1);
         end
         if (pop) begin
            head <= head + PW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         q_pc[tail]   <= imem_addr;
         q_inst[tail] <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic        inst_valid_d;
  logic [31:0] inst_d;
  logic [31:0] pc_d;

  int checks;
  int errors;

  // Outputs captured in the current cycle, sampled mid-cycle
  logic        o_req;
  logic        o_valid;
  logic [31:0] o_addr;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        pend;

  logic [31:0] exp_q[$];

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .stall_d      (stall_d),
    .inst_valid_d (inst_valid_d),
    .inst_d       (inst_d),
    .pc_d         (pc_d)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: every address holds a distinct, recognisable word
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  // Driver: one clock cycle. Inputs change on the falling edge, outputs are
  // captured 2 time units later, well before the next rising edge.
  // ack_mode: 0 = no ack, 1 = ack, 2 = ack one cycle after each request.
  task automatic step(input logic r, input int ack_mode, input logic rd,
                      input logic [31:0] rpc, input logic st);
    @(negedge clk);
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    stall_d     = st;
    #1;
    if (ack_mode == 2) imem_ack = pend;
    else               imem_ack = (ack_mode == 1);
    imem_rdata = inst_of(imem_addr);
    #1;
    o_req   = imem_req;
    o_addr  = imem_addr;
    o_valid = inst_valid_d;
    o_inst  = inst_d;
    o_pc    = pc_d;
    pend    = r ? 1'b0 : (o_req && !imem_ack);
  endtask

  task automatic do_reset();
    step(1'b1, 0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 0, 1'b0, 32'h0, 1'b0);
    pend = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", o_req); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", o_inst); end
    checks++; if (o_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", o_pc); end
    // First cycle after reset: request at RESET_PC
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", o_req); end
    checks++; if (o_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 0", o_addr); end
  endtask

  // Streaming with optional decode stall window, scored against the expected
  // in-order PC sequence 0x0, 0x4, 0x8, ...
  task automatic run_stream(input int stall_start, input int stall_len);
    logic [31:0] exp_addr;
    logic [31:0] e;
    logic        st;
    int          delivered;
    do_reset();
    exp_q.delete();
    for (int k = 0; k < 40; k++) exp_q.push_back(32'(k * 4));
    exp_addr  = 32'h0;
    delivered = 0;
    for (int i = 0; i < 60; i++) begin
      st = (i >= stall_start) && (i < stall_start + stall_len);
      step(1'b0, 2, 1'b0, 32'h0, st);
      if (o_req && imem_ack) begin
        checks++; if (o_addr !== exp_addr) begin errors++; $display("FAIL stream_addr: got %h expected %h", o_addr, exp_addr); end
        exp_addr = exp_addr + 32'd4;
      end
      if (o_valid && !st) begin
        e = exp_q.pop_front();
        checks++; if (o_pc !== e) begin errors++; $display("FAIL stream_pc: got %h expected %h", o_pc, e); end
        checks++; if (o_inst !== inst_of(e)) begin errors++; $display("FAIL stream_inst: got %h expected %h", o_inst, inst_of(e)); end
        delivered++;
      end
      if (stall_len > 0 && i == stall_start + stall_len - 1) begin
        // After a long enough stall the queue is full: no request, head valid
        checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL stall_full_req: got %b expected 0", o_req); end
        checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL stall_full_valid: got %b expected 1", o_valid); end
      end
    end
    checks++; if (delivered < 20) begin errors++; $display("FAIL stream_count: got %0d expected at least 20", delivered); end
  endtask

  task automatic test_stream();
    run_stream(0, 0);
  endtask

  task automatic test_backpressure();
    run_stream(8, 6);
  endtask

  task automatic test_redirect_wait();
    do_reset();
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);           // request 0x0 goes out
    step(1'b0, 0, 1'b1, 32'h40, 1'b0);          // redirect while waiting
    checks++; if (o_addr !== 32'h0) begin errors++; $display("FAIL rw_addr_hold0: got %h expected 0", o_addr); end
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h0) begin errors++; $display("FAIL rw_addr_hold1: got req %b addr %h expected req 1 addr 0", o_req, o_addr); end
    step(1'b0, 1, 1'b0, 32'h0, 1'b0);           // stale ack
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rw_drop_valid: got %b expected 0", o_valid); end
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h40) begin errors++; $display("FAIL rw_new_addr: got req %b addr %h expected req 1 addr 40", o_req, o_addr); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rw_queue_empty: got %b expected 0", o_valid); end
    step(1'b0, 1, 1'b0, 32'h0, 1'b0);           // ack for 0x40
`ifdef FETCH_BYPASS_EN
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h40) begin errors++; $display("FAIL rw_first_pc: got valid %b pc %h expected valid 1 pc 40", o_valid, o_pc); end
    checks++; if (o_inst !== inst_of(32'h40)) begin errors++; $display("FAIL rw_first_inst: got %h expected %h", o_inst, inst_of(32'h40)); end
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rw_bypass_not_pushed: got %b expected 0", o_valid); end
`else
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rw_latency: got %b expected 0", o_valid); end
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h40) begin errors++; $display("FAIL rw_first_pc: got valid %b pc %h expected valid 1 pc 40", o_valid, o_pc); end
    checks++; if (o_inst !== inst_of(32'h40)) begin errors++; $display("FAIL rw_first_inst: got %h expected %h", o_inst, inst_of(32'h40)); end
`endif
  endtask

  task automatic test_redirect_ack();
    do_reset();
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);           // request 0x0
    step(1'b0, 1, 1'b1, 32'h80, 1'b0);          // ack and redirect together
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ra_no_bypass: got %b expected 0", o_valid); end
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h80) begin errors++; $display("FAIL ra_next_addr: got req %b addr %h expected req 1 addr 80", o_req, o_addr); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ra_queue_empty: got %b expected 0", o_valid); end
  endtask

  task automatic test_misaligned();
    do_reset();
    step(1'b0, 0, 1'b1, 32'h43, 1'b0);          // redirect as request 0x0 issues
    checks++; if (o_addr !== 32'h0) begin errors++; $display("FAIL mis_old_addr: got %h expected 0", o_addr); end
    step(1'b0, 1, 1'b0, 32'h0, 1'b0);           // stale ack
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mis_drop: got %b expected 0", o_valid); end
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_addr !== 32'h40) begin errors++; $display("FAIL mis_aligned_addr: got %h expected 40", o_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b0, 0, 1'b0, 32'h0, 1'b1);           // request 0x0
    step(1'b0, 1, 1'b0, 32'h0, 1'b1);           // ack, pushed (stalled)
    step(1'b0, 0, 1'b0, 32'h0, 1'b1);           // request 0x4, one entry held
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin errors++; $display("FAIL rm_held: got valid %b pc %h expected valid 1 pc 0", o_valid, o_pc); end
    step(1'b1, 0, 1'b0, 32'h0, 1'b1);           // reset while waiting
    checks++; if (o_req !== 1'b0) begin errors++; $display("FAIL rm_req_in_rst: got %b expected 0", o_req); end
    step(1'b1, 1, 1'b0, 32'h0, 1'b0);           // stale ack during reset
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_valid_cleared: got %b expected 0", o_valid); end
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_req !== 1'b1 || o_addr !== 32'h0) begin errors++; $display("FAIL rm_first_req: got req %b addr %h expected req 1 addr 0", o_req, o_addr); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rm_stale_ignored: got %b expected 0", o_valid); end
    step(1'b0, 1, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_BYPASS_EN
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin errors++; $display("FAIL rm_refetch: got valid %b pc %h expected valid 1 pc 0", o_valid, o_pc); end
`else
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin errors++; $display("FAIL rm_refetch: got valid %b pc %h expected valid 1 pc 0", o_valid, o_pc); end
`endif
  endtask

  task automatic test_bypass();
    do_reset();
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);           // request 0x0
    step(1'b0, 1, 1'b0, 32'h0, 1'b0);           // ack, queue empty, no stall
`ifdef FETCH_BYPASS_EN
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin errors++; $display("FAIL bp_same_cycle: got valid %b pc %h expected valid 1 pc 0", o_valid, o_pc); end
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed: got %b expected 0", o_valid); end
`else
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_registered: got %b expected 0", o_valid); end
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin errors++; $display("FAIL bp_next_cycle: got valid %b pc %h expected valid 1 pc 0", o_valid, o_pc); end
`endif
    // With decode stalled the word is queued in both builds
    do_reset();
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1, 1'b0, 32'h0, 1'b1);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_stall_no_bypass: got %b expected 0", o_valid); end
    step(1'b0, 0, 1'b0, 32'h0, 1'b0);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h0) begin errors++; $display("FAIL bp_stall_pushed: got valid %b pc %h expected valid 1 pc 0", o_valid, o_pc); end
    checks++; if (o_inst !== inst_of(32'h0)) begin errors++; $display("FAIL bp_stall_inst: got %h expected %h", o_inst, inst_of(32'h0)); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    pend        = 1'b0;
    rst         = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    stall_d     = 1'b0;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_misaligned();
    test_reset_mid();
    test_bypass();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
